// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants for the EX->MEM pipeline stage: hold levels, reset values and bus strobes.
// The `define values mirror the core-wide defines.v header and are only set if not already present.
`ifndef Hold_Flag_Bus
`define Hold_Flag_Bus 2:0
`endif
`ifndef Hold_None
`define Hold_None 3'b000
`endif
`ifndef Hold_Pc
`define Hold_Pc 3'b001
`endif
`ifndef Hold_If
`define Hold_If 3'b010
`endif
`ifndef Hold_Id
`define Hold_Id 3'b011
`endif
`ifndef Hold_Ex
`define Hold_Ex 3'b100
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0
`endif
`ifndef ZeroReg
`define ZeroReg 5'h0
`endif
`ifndef WriteEnable
`define WriteEnable 1'b1
`endif
`ifndef WriteDisable
`define WriteDisable 1'b0
`endif
`ifndef RIB_REQ
`define RIB_REQ 1'b1
`endif
`ifndef RIB_NREQ
`define RIB_NREQ 1'b0
`endif

package ex_mem_pipe_pkg;

  typedef logic [`Hold_Flag_Bus] hold_flag_t;

  localparam hold_flag_t HOLD_NONE = `Hold_None;
  localparam hold_flag_t HOLD_PC   = `Hold_Pc;
  localparam hold_flag_t HOLD_IF   = `Hold_If;
  localparam hold_flag_t HOLD_ID   = `Hold_Id;
  localparam hold_flag_t HOLD_EX   = `Hold_Ex;

  localparam logic [31:0] ZERO_WORD     = `ZeroWord;
  localparam logic [4:0]  ZERO_REG      = `ZeroReg;
  localparam logic        WRITE_ENABLE  = `WriteEnable;
  localparam logic        WRITE_DISABLE = `WriteDisable;
  localparam logic        RIB_REQ       = `RIB_REQ;
  localparam logic        RIB_NREQ      = `RIB_NREQ;

  // A stage freezes for its own level and every level that stalls further upstream.
  function automatic logic hold_active(input hold_flag_t flag, input hold_flag_t level);
    return flag >= level;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_skid_buf.sv
// Generic valid/ready buffer with synchronous flush; one entry by default, main+skid with EX_MEM_SKID_EN.
// Only the valid flags are reset; payload registers are loaded on acceptance and never cleared.
module ex_mem_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o
);

`ifdef EX_MEM_SKID_EN
  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_fire, out_fire;

  // ready depends only on state, which breaks the ready_i timing path upstream.
  assign ready_o  = !skid_vld_q;
  assign in_fire  = valid_i && ready_o && !flush_i;
  assign out_fire = main_vld_q && ready_i;

  always_comb begin
    main_vld_d  = main_vld_q;
    skid_vld_d  = skid_vld_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_fire) begin
      if (skid_vld_q) begin
        main_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
      end else if (in_fire) begin
        main_data_d = data_i;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      if (main_vld_q) begin
        skid_vld_d  = 1'b1;
        skid_data_d = data_i;
      end else begin
        main_vld_d  = 1'b1;
        main_data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

  assign valid_o     = main_vld_q;
  assign data_o      = main_data_q;
  assign occupancy_o = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
`else
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              in_fire, out_fire;

  assign ready_o  = !vld_q || ready_i;
  assign in_fire  = valid_i && ready_o && !flush_i;
  assign out_fire = vld_q && ready_i;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (in_fire) begin
      vld_d  = 1'b1;
      data_d = data_i;
    end else if (out_fire) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid_o     = vld_q;
  assign data_o      = data_q;
  assign occupancy_o = {1'b0, vld_q};
`endif

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshake, hold and flush; EX_MEM_SKID_EN adds a skid entry.
// The payload is packed into one vector and stored by ex_mem_skid_buf; reset values are applied here.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int         XLEN       = 32,
  parameter int         REG_AW     = 5,
  parameter hold_flag_t HOLD_LEVEL = HOLD_EX
) (
  input  logic              clk,
  input  logic              rst,
  input  hold_flag_t        hold_flag_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic [XLEN-1:0]   mem_raddr_i,
  input  logic [XLEN-1:0]   mem_waddr_i,
  input  logic              mem_we_i,
  input  logic              mem_req_i,
  input  logic              reg_we_i,
  input  logic [XLEN-1:0]   reg_wdata_i,
  input  logic [REG_AW-1:0] reg_waddr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN-1:0]   mem_raddr_o,
  output logic [XLEN-1:0]   mem_waddr_o,
  output logic              mem_we_o,
  output logic              mem_req_o,
  output logic              reg_we_o,
  output logic [XLEN-1:0]   reg_wdata_o,
  output logic [REG_AW-1:0] reg_waddr_o,
  output logic [1:0]        occupancy_o
);

  localparam int PL_W = 4 * XLEN + REG_AW + 3;

  logic              hold_en;
  logic              buf_ready, buf_valid;
  logic [PL_W-1:0]   pl_in, pl_out;
  logic [XLEN-1:0]   mem_wdata_s, mem_raddr_s, mem_waddr_s, reg_wdata_s;
  logic [REG_AW-1:0] reg_waddr_s;
  logic              mem_we_s, mem_req_s, reg_we_s;

  assign hold_en = hold_active(hold_flag_i, HOLD_LEVEL);

  assign pl_in = {mem_wdata_i, mem_raddr_i, mem_waddr_i, reg_wdata_i,
                  reg_waddr_i, mem_we_i, mem_req_i, reg_we_i};

  // Hold is applied by masking both handshakes, so the buffer simply sees no transfers.
  ex_mem_skid_buf #(
    .DATA_W (PL_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .valid_i     (valid_i && !hold_en),
    .ready_o     (buf_ready),
    .data_i      (pl_in),
    .valid_o     (buf_valid),
    .ready_i     (ready_i && !hold_en),
    .data_o      (pl_out),
    .occupancy_o (occupancy_o)
  );

  assign {mem_wdata_s, mem_raddr_s, mem_waddr_s, reg_wdata_s,
          reg_waddr_s, mem_we_s, mem_req_s, reg_we_s} = pl_out;

  assign ready_o = buf_ready && !hold_en;
  assign valid_o = buf_valid && !hold_en;

  // Data fields stay as stored while idle; only the strobes are masked so a bubble never writes.
  assign mem_wdata_o = rst ? XLEN'(ZERO_WORD)  : mem_wdata_s;
  assign mem_raddr_o = rst ? XLEN'(ZERO_WORD)  : mem_raddr_s;
  assign mem_waddr_o = rst ? XLEN'(ZERO_WORD)  : mem_waddr_s;
  assign reg_wdata_o = rst ? XLEN'(ZERO_WORD)  : reg_wdata_s;
  assign reg_waddr_o = rst ? REG_AW'(ZERO_REG) : reg_waddr_s;

  assign mem_we_o  = (valid_o && !rst) ? mem_we_s  : WRITE_DISABLE;
  assign mem_req_o = (valid_o && !rst) ? mem_req_s : RIB_NREQ;
  assign reg_we_o  = (valid_o && !rst) ? reg_we_s  : WRITE_DISABLE;

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter XLEN, default 32, width of memory data, memory address and register write data fields.
REQ-002 Parameter REG_AW, default 5, width of register write address.
REQ-003 Parameter HOLD_LEVEL, default `Hold_Ex, hold_flag_i value at or above which the stage freezes.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 hold_flag_i  input  `Hold_Flag_Bus  pipeline hold level from the control unit.
REQ-007 flush_i  input  1  discard all buffered entries.
REQ-008 valid_i / ready_o  input / output  1 / 1  upstream handshake from ex.
REQ-009 mem_wdata_i, mem_raddr_i, mem_waddr_i  input  XLEN each  memory write data, read address and write address.
REQ-010 mem_we_i, mem_req_i, reg_we_i  input  1 each  memory write enable, memory request and register write enable.
REQ-011 reg_wdata_i  input  XLEN  register write data.
REQ-012 reg_waddr_i  input  REG_AW  register write address.
REQ-013 valid_o / ready_i  output / input  1 / 1  downstream handshake to mem.
REQ-014 The stage SHALL provide one *_o output for every *_i payload field, of identical width.
REQ-015 occupancy_o  output  2  number of valid entries held, 0..2.

Function
REQ-016 A transfer in SHALL occur when valid_i && ready_o && !hold_en && !flush_i; a transfer out SHALL occur when valid_o && ready_i.
REQ-017 hold_en SHALL be (hold_flag_i >= HOLD_LEVEL).
REQ-018 While hold_en is 1, ready_o and valid_o SHALL be 0 and all stored entries and payload outputs SHALL remain unchanged.
REQ-019 Latency SHALL be one cycle: an entry accepted into an empty stage SHALL appear on valid_o and the payload outputs in the next cycle.
REQ-020 Entries SHALL leave in acceptance order, with no loss and no duplication.
REQ-021 flush_i SHALL take priority over hold, input and output: the next cycle SHALL have occupancy 0 and valid_o 0, and the entry on valid_i that cycle SHALL be dropped.
REQ-022 Whenever valid_o is 0, mem_we_o, mem_req_o and reg_we_o SHALL be 0, so that a bubble never writes anything.
REQ-023 A simultaneous transfer in and out SHALL leave the occupancy unchanged.
REQ-024 payload outputs SHALL be driven from registers only.

Reset
REQ-025 While rst is asserted, occupancy and valid_o SHALL be 0.
REQ-026 While rst is asserted, all data and address outputs SHALL be `ZeroWord and reg_waddr_o SHALL be `ZeroReg.
REQ-027 While rst is asserted, mem_we_o and reg_we_o SHALL be `WriteDisable and mem_req_o SHALL be `RIB_NREQ.
REQ-028 ready_o SHALL be 1 in the first cycle after rst deasserts, unless hold_en is 1.
REQ-029 Reset asserted mid-transfer SHALL discard every entry with no partial output.

Configuration
REQ-030 The macro EX_MEM_SKID_EN SHALL select the buffer depth at compile time.
REQ-031 With EX_MEM_SKID_EN defined: two entries (main plus skid); ready_o SHALL be registered as !skid_full && !hold_en.
REQ-032 With EX_MEM_SKID_EN defined: an entry accepted while the output stalls SHALL go to the skid entry.
REQ-033 With EX_MEM_SKID_EN defined: when main drains, the skid entry SHALL move to main in the same cycle; sustained throughput SHALL be 1 per cycle.
REQ-034 Without EX_MEM_SKID_EN: one entry; ready_o SHALL be (!valid_o || ready_i) && !hold_en, combinational from ready_i; occupancy_o SHALL never exceed 1.

Structure
REQ-035 Hold levels, reset constants, `Hold_Flag_Bus, `RIB_NREQ and `WriteDisable SHALL come from the shared defines.v header; no new literals SHALL be introduced in the block.
REQ-036 The payload SHALL be packed into one vector of width 4*XLEN+REG_AW+3.
REQ-037 The packed payload SHALL be stored by one sub-module, ex_mem_skid_buf, a generic valid/ready buffer parametrised by payload width with a flush input.
REQ-038 Reset payload values SHALL be injected by the ex_mem_pipe wrapper.

Verification
REQ-039 After reset: valid_i=1, ready_i=1, reg_wdata_i=0x12345678 -> next cycle valid_o=1 and reg_wdata_o=0x12345678, then 1 transfer per cycle for 8 back-to-back words.
REQ-040 (EX_MEM_SKID_EN) ready_i=0 for 3 cycles with valid_i held -> occupancy_o reaches 2 and ready_o goes to 0. Then ready_i=1 -> both entries emerge in order with no gap.
REQ-041 hold_flag_i=`Hold_Ex for 2 cycles with occupancy 1 -> valid_o=0 and ready_o=0 during hold. After hold: the same payload is presented, unchanged.
REQ-042 flush_i=1 with occupancy 2 and valid_i=1 -> next cycle valid_o=0, occupancy_o=0 and mem_we_o=0. The flushed-cycle input never appears at the output.
REQ-043 rst pulsed for 1 cycle mid-stream with mem_we_i=1 -> all outputs at reset values asynchronously, no write strobe emitted, and acceptance resumes the next cycle.
REQ-044 Random valid_i/ready_i/hold at 50% for 10k cycles, compared against a reference FIFO model -> order is preserved and occupancy_o matches the model every cycle.
